// File: rtl/multicycle_ctrl_pkg.sv
// Shared control definitions for the multi-cycle MIPS core: opcodes, state codes and
// datapath select encodings used by the controller, decoder and datapath muxes.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXE    = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } stateT;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BEQ,
    CLS_JR,
    CLS_JAL
  } instrClassT;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] NPC_SEQ    = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_JAL    = 3'd2;
  localparam logic [2:0] NPC_JR     = 3'd3;

  localparam logic [2:0] REGDST_RT = 3'd0;
  localparam logic [2:0] REGDST_RD = 3'd1;
  localparam logic [2:0] REGDST_RA = 3'd2;

  localparam logic [2:0] RWSEL_ALU = 3'd0;
  localparam logic [2:0] RWSEL_MEM = 3'd1;
  localparam logic [2:0] RWSEL_PC4 = 3'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;

  localparam logic [2:0] EXT_ZERO = 3'd0;
  localparam logic [2:0] EXT_SIGN = 3'd1;
  localparam logic [2:0] EXT_LUI  = 3'd2;

  localparam logic [2:0] MEM_NONE = 3'd0;
  localparam logic [2:0] MEM_WORD = 3'd1;
  localparam logic [2:0] MEM_HALF = 3'd2;
  localparam logic [2:0] MEM_BYTE = 3'd3;

  localparam logic [2:0] DEXT_WORD = 3'd0;
  localparam logic [2:0] DEXT_BYTE = 3'd2;
  localparam logic [2:0] DEXT_HALF = 3'd4;

  typedef struct packed {
    instrClassT cls;
    logic [2:0] regDst;
    logic [2:0] regWriteSel;
    logic       aluSrc;
    logic [2:0] aluControl;
    logic [2:0] extOp;
    logic [2:0] memWidth;
    logic [2:0] dataExtOp;
  } decodeT;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and Zero flow in, strobes and selects flow out.
interface multicycle_ctrl_if #(parameter int RET_W = 32);
  logic [5:0]       Op;
  logic [5:0]       Func;
  logic             Zero;
  logic             IRWrite;
  logic             PCWrite;
  logic [2:0]       nPCSel;
  logic             RegWrite;
  logic [2:0]       RegDst;
  logic [2:0]       RegWriteSel;
  logic             ALUSrc;
  logic [2:0]       ALUControl;
  logic [2:0]       ExtOp;
  logic [2:0]       MemWrite;
  logic [2:0]       DataExtOp;
  logic [2:0]       State;
  logic [RET_W-1:0] Retired;

  modport master (
    input  Op, Func, Zero,
    output IRWrite, PCWrite, nPCSel, RegWrite, RegDst, RegWriteSel, ALUSrc,
           ALUControl, ExtOp, MemWrite, DataExtOp, State, Retired
  );

  modport slave (
    output Op, Func, Zero,
    input  IRWrite, PCWrite, nPCSel, RegWrite, RegDst, RegWriteSel, ALUSrc,
           ALUControl, ExtOp, MemWrite, DataExtOp, State, Retired
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction decode: Op/Func -> instruction class and datapath select fields.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output decodeT     dec
);

  // NOTE: every field gets a default before the case so no path leaves a latch behind.
  always_comb begin
    dec     = '0;
    dec.cls = CLS_NOP;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  begin dec.cls = CLS_ALU; dec.regDst = REGDST_RD; dec.aluControl = ALU_ADD; end
          FN_SUB:  begin dec.cls = CLS_ALU; dec.regDst = REGDST_RD; dec.aluControl = ALU_SUB; end
          FN_JR:   dec.cls = CLS_JR;
          default: ;
        endcase
      end
      OP_ORI: begin
        dec.cls = CLS_ALU; dec.extOp = EXT_ZERO; dec.aluSrc = 1'b1; dec.aluControl = ALU_OR;
      end
      OP_LUI: begin
        dec.cls = CLS_ALU; dec.extOp = EXT_LUI; dec.aluSrc = 1'b1; dec.aluControl = ALU_ADD;
      end
      OP_LW, OP_LH, OP_LB: begin
        dec.cls         = CLS_LOAD;
        dec.extOp       = EXT_SIGN;
        dec.aluSrc      = 1'b1;
        dec.regWriteSel = RWSEL_MEM;
        dec.dataExtOp   = (op == OP_LW) ? DEXT_WORD : (op == OP_LH) ? DEXT_HALF : DEXT_BYTE;
      end
      OP_SW, OP_SH, OP_SB: begin
        dec.cls      = CLS_STORE;
        dec.extOp    = EXT_SIGN;
        dec.aluSrc   = 1'b1;
        dec.memWidth = (op == OP_SW) ? MEM_WORD : (op == OP_SH) ? MEM_HALF : MEM_BYTE;
      end
      OP_BEQ: begin
        dec.cls = CLS_BEQ; dec.aluControl = ALU_SUB;
      end
      OP_JAL: begin
        dec.cls = CLS_JAL; dec.regDst = REGDST_RA; dec.regWriteSel = RWSEL_PC4;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main sequencer of the multi-cycle MIPS core: walks FETCH..WB per instruction class,
// issues Moore write strobes, and counts retired instructions.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int RET_W = 32
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_ctrl_if.master    bus
);

  stateT            state;
  stateT            stateNext;
  decodeT           dec;
  logic [RET_W-1:0] retired;
  logic             irWrite;
  logic             retire;
  logic             regWrite;
  logic [2:0]       memWrite;
  logic [2:0]       npcSel;

  multicycle_ctrl_decode u_decode (
    .op   (bus.Op),
    .func (bus.Func),
    .dec  (dec)
  );

  always_comb begin
    stateNext = FETCH;
    irWrite   = 1'b0;
    retire    = 1'b0;
    regWrite  = 1'b0;
    memWrite  = MEM_NONE;
    npcSel    = NPC_SEQ;
    case (state)
      FETCH: begin
        irWrite   = 1'b1;
        stateNext = DECODE;
      end
      DECODE: begin
        case (dec.cls)
          CLS_NOP: retire = 1'b1;
          CLS_JAL: stateNext = WB;
          default: stateNext = EXE;
        endcase
      end
      EXE: begin
        case (dec.cls)
          CLS_ALU:              stateNext = WB;
          CLS_LOAD, CLS_STORE:  stateNext = MEM;
          CLS_BEQ: begin retire = 1'b1; npcSel = bus.Zero ? NPC_BRANCH : NPC_SEQ; end
          CLS_JR:  begin retire = 1'b1; npcSel = NPC_JR; end
          // Inputs changed under us; close out rather than stall.
          default: retire = 1'b1;
        endcase
      end
      MEM: begin
        if (dec.cls == CLS_LOAD) begin
          stateNext = WB;
        end else begin
          retire = 1'b1;
          if (dec.cls == CLS_STORE) memWrite = dec.memWidth;
        end
      end
      WB: begin
        retire   = 1'b1;
        regWrite = dec.cls inside {CLS_ALU, CLS_LOAD, CLS_JAL};
        if (dec.cls == CLS_JAL) npcSel = NPC_JAL;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= FETCH;
      retired <= '0;
    end else begin
      state <= stateNext;
      if (retire) retired <= retired + RET_W'(1);
    end
  end

  // Strobes are qualified by reset so an abandoned instruction leaves no side effects.
  assign bus.IRWrite  = reset & irWrite;
  assign bus.PCWrite  = reset & retire;
  assign bus.RegWrite = reset & regWrite;
  assign bus.MemWrite = reset ? memWrite : MEM_NONE;
  assign bus.nPCSel   = reset ? npcSel : NPC_SEQ;

  assign bus.RegDst      = (state == FETCH) ? '0 : dec.regDst;
  assign bus.RegWriteSel = (state == FETCH) ? '0 : dec.regWriteSel;
  assign bus.ALUSrc      = (state == FETCH) ? 1'b0 : dec.aluSrc;
  assign bus.ALUControl  = (state == FETCH) ? '0 : dec.aluControl;
  assign bus.ExtOp       = (state == FETCH) ? '0 : dec.extOp;
  assign bus.DataExtOp   = (state == FETCH) ? '0 : dec.dataExtOp;

  assign bus.State   = state;
  assign bus.Retired = retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a per-instruction reference model queues the
// expected per-cycle outputs; a monitor compares them on the falling clock edge.
module tb_multicycle_ctrl;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4;

  typedef struct {
    string      name;
    int         cpi;
    logic [2:0] path [5];
    bit         writesReg;
    logic [2:0] memW;
    logic [2:0] npc;
    logic [2:0] regDst;
    logic [2:0] rws;
    bit         aluSrc;
    logic [2:0] aluc;
    logic [2:0] extOp;
    logic [2:0] dext;
  } instrT;

  typedef struct {
    string       tag;
    bit          inReset;
    bit          chkState;
    bit          chkRet;
    logic [2:0]  state;
    bit          irW;
    bit          pcW;
    bit          regW;
    logic [2:0]  memW;
    logic [2:0]  npc;
    logic [2:0]  regDst;
    logic [2:0]  rws;
    bit          aluSrc;
    logic [2:0]  aluc;
    logic [2:0]  extOp;
    logic [2:0]  dext;
    logic [31:0] ret;
  } expT;

  logic clk;
  logic reset;

  multicycle_ctrl_if #(.RET_W(32)) bus ();
  multicycle_ctrl_if #(.RET_W(3))  busSmall ();

  assign busSmall.Op   = bus.Op;
  assign busSmall.Func = bus.Func;
  assign busSmall.Zero = bus.Zero;

  multicycle_ctrl #(.RET_W(32)) dut      (.clk(clk), .reset(reset), .bus(bus));
  multicycle_ctrl #(.RET_W(3))  dutSmall (.clk(clk), .reset(reset), .bus(busSmall));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  expT         expQ [$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] modelRet = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: instruction table taken straight from the ISA description.
  function automatic instrT refModel(input logic [5:0] op, input logic [5:0] func, input bit zero);
    instrT m;
    m.name = "nop"; m.cpi = 2; m.writesReg = 0; m.memW = 0; m.npc = 0;
    m.regDst = 0; m.rws = 0; m.aluSrc = 0; m.aluc = 0; m.extOp = 0; m.dext = 0;
    for (int i = 0; i < 5; i++) m.path[i] = S_F;
    m.path[1] = S_D;
    case (op)
      6'h00: begin
        if (func == 6'h20)      begin m.name = "add"; m.cpi = 4; m.writesReg = 1; m.regDst = 1; m.aluc = 0; end
        else if (func == 6'h22) begin m.name = "sub"; m.cpi = 4; m.writesReg = 1; m.regDst = 1; m.aluc = 1; end
        else if (func == 6'h08) begin m.name = "jr";  m.cpi = 3; m.npc = 3; end
      end
      6'h0d: begin m.name = "ori"; m.cpi = 4; m.writesReg = 1; m.aluSrc = 1; m.aluc = 2; m.extOp = 0; end
      6'h0f: begin m.name = "lui"; m.cpi = 4; m.writesReg = 1; m.aluSrc = 1; m.extOp = 2; end
      6'h23, 6'h21, 6'h20: begin
        m.name = (op == 6'h23) ? "lw" : (op == 6'h21) ? "lh" : "lb";
        m.cpi = 5; m.writesReg = 1; m.rws = 1; m.aluSrc = 1; m.extOp = 1;
        m.dext = (op == 6'h23) ? 3'd0 : (op == 6'h21) ? 3'd4 : 3'd2;
      end
      6'h2b, 6'h29, 6'h28: begin
        m.name = (op == 6'h2b) ? "sw" : (op == 6'h29) ? "sh" : "sb";
        m.cpi = 4; m.aluSrc = 1; m.extOp = 1;
        m.memW = (op == 6'h2b) ? 3'd1 : (op == 6'h29) ? 3'd2 : 3'd3;
      end
      6'h04: begin m.name = "beq"; m.cpi = 3; m.aluc = 1; m.npc = zero ? 3'd1 : 3'd0; end
      6'h03: begin m.name = "jal"; m.cpi = 3; m.writesReg = 1; m.regDst = 2; m.rws = 2; m.npc = 2; end
      default: ;
    endcase
    // Path shape follows from CPI and class: loads add MEM, stores end in MEM, jal skips EXE.
    if (m.name == "jal") m.path[2] = S_W;
    else if (m.cpi >= 3) m.path[2] = S_E;
    if (m.cpi == 5) begin m.path[3] = S_M; m.path[4] = S_W; end
    else if (m.cpi == 4) m.path[3] = (m.memW != 0) ? S_M : S_W;
    return m;
  endfunction

  function automatic expT cycleExp(input instrT m, input int k);
    expT e;
    bit  last;
    last       = (k == m.cpi - 1);
    e.tag      = $sformatf("%s.c%0d", m.name, k);
    e.inReset  = 0;
    e.chkState = 1;
    e.chkRet   = 1;
    e.state    = m.path[k];
    e.irW      = (k == 0);
    e.pcW      = last;
    e.regW     = last && m.writesReg;
    e.memW     = last ? m.memW : 3'd0;
    e.npc      = last ? m.npc : 3'd0;
    e.regDst   = (k == 0) ? 3'd0 : m.regDst;
    e.rws      = (k == 0) ? 3'd0 : m.rws;
    e.aluSrc   = (k == 0) ? 1'b0 : m.aluSrc;
    e.aluc     = (k == 0) ? 3'd0 : m.aluc;
    e.extOp    = (k == 0) ? 3'd0 : m.extOp;
    e.dext     = (k == 0) ? 3'd0 : m.dext;
    e.ret      = modelRet;
    return e;
  endfunction

  function automatic expT resetExp(input string tag, input bit chkState, input logic [2:0] st,
                                   input bit chkRet);
    expT e;
    e = cycleExp(refModel(6'h00, 6'h00, 1'b0), 1);
    e.tag = tag; e.inReset = 1; e.chkState = chkState; e.state = st; e.chkRet = chkRet;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] func, input bit zero);
    instrT m;
    m = refModel(op, func, zero);
    bus.Op = op; bus.Func = func; bus.Zero = zero;
    for (int k = 0; k < m.cpi; k++) expQ.push_back(cycleExp(m, k));
    repeat (m.cpi) step();
    modelRet++;
  endtask

  // Monitor: one expected record per clock, compared away from the active edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      expT e;
      e = expQ.pop_front();
      if (e.chkState) check({e.tag, ".State"}, 32'(bus.State), 32'(e.state));
      if (e.chkRet) begin
        check({e.tag, ".Retired"}, bus.Retired, e.ret);
        check({e.tag, ".RetiredW3"}, 32'(busSmall.Retired), 32'(e.ret[2:0]));
      end
      if (e.inReset) begin
        check({e.tag, ".IRWrite"},  32'(bus.IRWrite),  0);
        check({e.tag, ".PCWrite"},  32'(bus.PCWrite),  0);
        check({e.tag, ".RegWrite"}, 32'(bus.RegWrite), 0);
        check({e.tag, ".MemWrite"}, 32'(bus.MemWrite), 0);
      end else begin
        check({e.tag, ".IRWrite"},     32'(bus.IRWrite),     32'(e.irW));
        check({e.tag, ".PCWrite"},     32'(bus.PCWrite),     32'(e.pcW));
        check({e.tag, ".RegWrite"},    32'(bus.RegWrite),    32'(e.regW));
        check({e.tag, ".MemWrite"},    32'(bus.MemWrite),    32'(e.memW));
        check({e.tag, ".nPCSel"},      32'(bus.nPCSel),      32'(e.npc));
        check({e.tag, ".RegDst"},      32'(bus.RegDst),      32'(e.regDst));
        check({e.tag, ".RegWriteSel"}, 32'(bus.RegWriteSel), 32'(e.rws));
        check({e.tag, ".ALUSrc"},      32'(bus.ALUSrc),      32'(e.aluSrc));
        check({e.tag, ".ALUControl"},  32'(bus.ALUControl),  32'(e.aluc));
        check({e.tag, ".ExtOp"},       32'(bus.ExtOp),       32'(e.extOp));
        check({e.tag, ".DataExtOp"},   32'(bus.DataExtOp),   32'(e.dext));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [11:0] known [15];

  initial begin
    logic [5:0] op;
    logic [5:0] func;
    instrT      m;

    known = '{ {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h08}, {6'h00, 6'h00}, {6'h0d, 6'h11},
               {6'h0f, 6'h05}, {6'h23, 6'h01}, {6'h21, 6'h02}, {6'h20, 6'h03}, {6'h2b, 6'h04},
               {6'h29, 6'h06}, {6'h28, 6'h07}, {6'h04, 6'h09}, {6'h03, 6'h0a}, {6'h3f, 6'h3f} };

    reset = 1'b0;
    bus.Op = '0; bus.Func = '0; bus.Zero = 1'b0;
    step();

    // Three cycles in reset: no strobes at all.
    for (int i = 0; i < 3; i++) expQ.push_back(resetExp($sformatf("rst.c%0d", i), 0, S_F, 0));
    repeat (3) step();
    reset = 1'b1;
    modelRet = 0;

    // nop loop: FETCH/DECODE with PCWrite every second cycle.
    repeat (3) issue(6'h00, 6'h00, 1'b0);

    // Directed: every instruction plus both beq outcomes and an unknown opcode.
    issue(6'h23, 6'h00, 1'b0);  // lw
    issue(6'h28, 6'h00, 1'b0);  // sb
    issue(6'h21, 6'h00, 1'b0);  // lh
    issue(6'h04, 6'h00, 1'b1);  // beq taken
    issue(6'h04, 6'h00, 1'b0);  // beq not taken
    issue(6'h03, 6'h00, 1'b0);  // jal
    issue(6'h00, 6'h08, 1'b0);  // jr
    issue(6'h00, 6'h20, 1'b0);  // add
    issue(6'h00, 6'h22, 1'b0);  // sub
    issue(6'h0d, 6'h00, 1'b0);  // ori
    issue(6'h0f, 6'h00, 1'b0);  // lui
    issue(6'h2b, 6'h00, 1'b0);  // sw
    issue(6'h29, 6'h00, 1'b0);  // sh
    issue(6'h20, 6'h00, 1'b0);  // lb
    issue(6'h3e, 6'h15, 1'b1);  // unknown

    // Reset during MEM of sw abandons it: no strobes that cycle, Retired cleared.
    m = refModel(6'h2b, 6'h00, 1'b0);
    bus.Op = 6'h2b; bus.Func = 6'h00; bus.Zero = 1'b0;
    for (int k = 0; k < 3; k++) expQ.push_back(cycleExp(m, k));
    repeat (3) step();
    reset = 1'b0;
    expQ.push_back(resetExp("swAbort.mem", 1, S_M, 1));
    step();
    reset = 1'b1;
    modelRet = 0;
    issue(6'h00, 6'h00, 1'b0);

    // Randomized stream; long enough to wrap the 3-bit counter several times.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        int idx;
        idx  = $urandom_range(0, 14);
        op   = known[idx][11:6];
        func = known[idx][5:0];
      end else begin
        op   = 6'($urandom_range(0, 63));
        func = 6'($urandom_range(0, 63));
      end
      issue(op, func, 1'($urandom_range(0, 1)));
    end

    repeat (2) step();
    check("queueDrained", 32'(expQ.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
